alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Sequencer for the 3-operand byte datapath: takes one 16-bit instruction at a time over a valid/ready
//  handshake, reads two source bytes from the single-port 16x8 register memory, runs AND/ADD/SUB/MUL,
//  and writes the result back. Sits between the instruction source (bench or fetch unit) and the memory array.
// PARAMETERS
//  DATA_W  8  operand/result width in bits
//  ADDR_W  4  register-memory address width; instruction width = 4 + 3*ADDR_W (16 by default)
// PORTS
//  clk          in   1        single clock; all state updates on rising edge
//  rst          in   1        synchronous, active-high reset
//  instr_valid  in   1        instruction present on instr
//  instr_ready  out  1        sequencer accepts instr this cycle
//  instr        in   16       [15:12] opcode, [11:8] src A (r1), [7:4] src B (r2), [3:0] dest (r3)
//  mem_addr     out  ADDR_W   memory address (read or write)
//  mem_we       out  1        write strobe, one cycle
//  mem_wdata    out  DATA_W   write data
//  mem_rdata    in   DATA_W   read data, valid 1 cycle after mem_addr (synchronous read)
//  busy         out  1        high in any state except IDLE
//  done         out  1        one-cycle pulse when an instruction retires
//  illegal      out  1        one-cycle pulse with done for an undefined opcode
//  result       out  DATA_W   last computed result, held until next EXEC
// BEHAVIOUR
//  Opcodes: 4'b1000 AND, 4'b1011 ADD, 4'b1100 SUB (A-B), 4'b1101 MUL; all others are illegal.
//  Arithmetic: DATA_W-bit, wraps modulo 2^DATA_W; MUL keeps the low DATA_W bits of the 2*DATA_W product.
//  FSM states: IDLE, RD_A, RD_B, EXEC, WB, ERR.
//   IDLE: instr_ready=1; on valid latch instr -> RD_A (legal) or ERR (illegal).
//   RD_A: mem_addr=srcA -> RD_B.
//   RD_B: mem_addr=srcB; op_a<=mem_rdata -> EXEC.
//   EXEC: op_b<=mem_rdata; result<=f(op_a,mem_rdata) -> WB.
//   WB: mem_addr=dest, mem_we=1, mem_wdata=result, done=1; instr_ready=1;
//       if valid: latch next instr -> RD_A/ERR; else -> IDLE.
//   ERR: done=1, illegal=1, no memory access; instr_ready=0 -> IDLE.
//  Latency: accept at cycle 0 -> write and done at cycle 4; back-to-back throughput 1 instr / 4 cycles.
//  RAW hazard: dest of instr N == source of instr N+1 is safe; the write lands at the WB edge, before
//   RD_A of N+1 issues its address.
//  src A == src B, and dest == src, are legal; each source is read once, the dest write follows.
//  instr_valid held while instr_ready=0 is ignored; instr may change freely when not accepted.
//  Reset: state=IDLE; result=0; done, illegal, mem_we=0; mem_addr=0; mem_wdata=0.
//   mem_we is gated by !rst, so reset asserted during WB suppresses the write. An in-flight instruction
//   is dropped with no done.
//  Idle outputs: mem_addr=0, mem_we=0.
// CONFIGURATION
//  ALU_SEQ_FLAGS_EN defined: adds outputs flag_z (1b) and flag_c (1b), registered in EXEC, reset 0.
//   flag_z = result==0.
//   flag_c = carry-out for ADD, borrow for SUB, any nonzero high product bit for MUL, 0 for AND.
//  ALU_SEQ_FLAGS_EN undefined: flag ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Package alu_seq_pkg: opcode localparams (OP_AND, OP_ADD, OP_SUB, OP_MUL), FSM state encoding,
//   instruction field-slice constants.
//  Sub-module alu_seq_alu: combinational op/a/b -> result (+ flags when ALU_SEQ_FLAGS_EN).
//   FSM, handshake and memory sequencing stay in alu_seq_ctrl.
// TESTING
//  Bench provides a behavioural 16x8 memory with synchronous read and write-first. Preload mem[3]=8'd20,
//  mem[7]=8'd5, mem[13]=8'd9, mem[2]=8'd4, mem[14]=8'd3, mem[15]=8'd12, mem[5]=8'd7, mem[6]=8'hF0, mem[7]..
//  1) ADD 16'hB372 (mem[3]+mem[7]->mem[2]): done at cycle 4; mem[2]=8'd25; mem_we high exactly 1 cycle.
//  2) Back-to-back SUB 16'hCE25 (mem[14]=3 - mem[2]=4 -> mem[5]) after scenario 1 with valid held:
//     reads the updated mem[2]=25; mem[5]=8'hEA (3-25 wraps); 4-cycle spacing between done pulses.
//  3) MUL 16'hDF5B (mem[15]=12 * mem[5]=0xEA): mem[11]=8'hF8 (low byte of 2808); with flags, flag_c=1.
//  4) AND 16'h8677 (mem[6]=0xF0 & mem[7]=5 -> mem[7]): mem[7]=8'h00; same-register src/dest;
//     with flags, flag_z=1.
//  5) Illegal opcode 16'h0123: done+illegal pulse at cycle 1; mem_we never asserts; result unchanged.
//  6) rst asserted in the WB cycle of an ADD: no write to dest; next cycle busy=0, instr_ready=1,
//     all outputs at reset values.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-datapath sequencer: opcodes, FSM states, instruction field layout.
// Optional flag outputs are enabled elsewhere by defining ALU_SEQ_FLAGS_EN.
package alu_seq_pkg;

    localparam int OPC_W = 4;

    // Field slots within the instruction, counted in units of ADDR_W from the LSB
    localparam int FLD_DEST = 0;
    localparam int FLD_SRCB = 1;
    localparam int FLD_SRCA = 2;
    localparam int FLD_OPC  = 3;

    localparam logic [OPC_W-1:0] OP_AND = 4'b1000;
    localparam logic [OPC_W-1:0] OP_ADD = 4'b1011;
    localparam logic [OPC_W-1:0] OP_SUB = 4'b1100;
    localparam logic [OPC_W-1:0] OP_MUL = 4'b1101;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        EXEC,
        WB,
        ERR
    } state_t;

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        logic legal;
        case (op)
            OP_AND, OP_ADD, OP_SUB, OP_MUL: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational byte ALU: AND/ADD/SUB/MUL, results wrap to DATA_W bits.
// Zero/carry flag outputs exist only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq_alu
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic [OPC_W-1:0]  i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              o_flag_z,
    output logic              o_flag_c
`endif
);

`ifdef ALU_SEQ_FLAGS_EN
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_prod;

    // Wide sum and product keep the carry and high product bits for the flags
    always_comb begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        w_prod   = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
        o_result = '0;
        o_flag_c = 1'b0;
        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_flag_c = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_result = i_a - i_b;
                o_flag_c = (i_a < i_b);
            end
            OP_MUL: begin
                o_result = w_prod[DATA_W-1:0];
                o_flag_c = |w_prod[2*DATA_W-1:DATA_W];
            end
            default: o_result = '0;
        endcase
        o_flag_z = (o_result == '0);
    end
`else
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_AND:  o_result = i_a & i_b;
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_MUL:  o_result = i_a * i_b;
            default: o_result = '0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer: valid/ready intake, two synchronous memory reads, ALU execute, write-back.
// Define ALU_SEQ_FLAGS_EN to add the registered flag_z/flag_c outputs.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [OPC_W+3*ADDR_W-1:0]  instr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       illegal,
    output logic [DATA_W-1:0]          result
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                       flag_z,
    output logic                       flag_c
`endif
);

    localparam int INSTR_W = OPC_W + 3*ADDR_W;

    state_t               r_state;
    state_t               w_next;
    logic [INSTR_W-1:0]   r_instr;
    logic [DATA_W-1:0]    r_op_a;
    logic [DATA_W-1:0]    r_result;
    logic                 w_accept;
    logic [OPC_W-1:0]     w_in_opc;
    logic [OPC_W-1:0]     w_opc;
    logic [ADDR_W-1:0]    w_src_a;
    logic [ADDR_W-1:0]    w_src_b;
    logic [ADDR_W-1:0]    w_dest;
    logic [DATA_W-1:0]    w_alu_y;

    assign w_in_opc = instr[FLD_OPC*ADDR_W +: OPC_W];
    assign w_opc    = r_instr[FLD_OPC*ADDR_W +: OPC_W];
    assign w_src_a  = r_instr[FLD_SRCA*ADDR_W +: ADDR_W];
    assign w_src_b  = r_instr[FLD_SRCB*ADDR_W +: ADDR_W];
    assign w_dest   = r_instr[FLD_DEST*ADDR_W +: ADDR_W];

`ifdef ALU_SEQ_FLAGS_EN
    logic w_flag_z;
    logic w_flag_c;
    logic r_flag_z;
    logic r_flag_c;

    assign flag_z = r_flag_z;
    assign flag_c = r_flag_c;
`endif

    // Operand B is taken straight off the read port in EXEC, so it is never registered
    alu_seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_opc),
        .i_a      (r_op_a),
        .i_b      (mem_rdata),
        .o_result (w_alu_y)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .o_flag_z (w_flag_z),
        .o_flag_c (w_flag_c)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_instr  <= '0;
            r_op_a   <= '0;
            r_result <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_instr <= instr;
            end
            if (r_state == RD_B) begin
                r_op_a <= mem_rdata;
            end
            if (r_state == EXEC) begin
                r_result <= w_alu_y;
`ifdef ALU_SEQ_FLAGS_EN
                r_flag_z <= w_flag_z;
                r_flag_c <= w_flag_c;
`endif
            end
        end
    end

    // Reset forces all strobes low so a WB cycle under reset neither writes nor retires
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        instr_ready = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_accept = 1'b1;
                    w_next   = is_legal_op(w_in_opc) ? RD_A : ERR;
                end
            end
            RD_A: begin
                mem_addr = w_src_a;
                w_next   = RD_B;
            end
            RD_B: begin
                mem_addr = w_src_b;
                w_next   = EXEC;
            end
            EXEC: begin
                w_next = WB;
            end
            WB: begin
                mem_addr    = w_dest;
                mem_we      = 1'b1;
                mem_wdata   = r_result;
                done        = 1'b1;
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_accept = 1'b1;
                    w_next   = is_legal_op(w_in_opc) ? RD_A : ERR;
                end else begin
                    w_next = IDLE;
                end
            end
            ERR: begin
                done    = 1'b1;
                illegal = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            w_accept    = 1'b0;
            instr_ready = 1'b0;
            mem_addr    = '0;
            mem_we      = 1'b0;
            mem_wdata   = '0;
            done        = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign busy   = (r_state != IDLE);
    assign result = r_result;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 16x8 synchronous, write-first memory.
// Flag checks are included when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        instrValid;
    logic        instrReady;
    logic [15:0] instr;
    logic [3:0]  memAddr;
    logic        memWe;
    logic [7:0]  memWdata;
    logic [7:0]  memRdata;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [7:0]  result;
`ifdef ALU_SEQ_FLAGS_EN
    logic        flagZ;
    logic        flagC;
`endif

    logic [7:0]  memArray [16];
    int          testsRun;
    int          testsFailed;

    alu_seq_ctrl #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instrValid),
        .instr_ready (instrReady),
        .instr       (instr),
        .mem_addr    (memAddr),
        .mem_we      (memWe),
        .mem_wdata   (memWdata),
        .mem_rdata   (memRdata),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .result      (result)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flag_z      (flagZ),
        .flag_c      (flagC)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first: a read of the address being written returns the new data
    always @(posedge clk) begin
        if (memWe) begin
            memArray[memAddr] <= memWdata;
            memRdata          <= memWdata;
        end else begin
            memRdata <= memArray[memAddr];
        end
    end

    task automatic applyStimulus(input logic rstIn, input logic validIn, input logic [15:0] instrIn);
        @(posedge clk);
        #1;
        rst        = rstIn;
        instrValid = validIn;
        instr      = instrIn;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        instrValid  = 1'b0;
        instr       = 16'h0000;
        memRdata    = 8'h00;
        for (int i = 0; i < 16; i++) memArray[i] = 8'h00;
        memArray[3]  = 8'd20;
        memArray[7]  = 8'd5;
        memArray[13] = 8'd9;
        memArray[2]  = 8'd4;
        memArray[14] = 8'd3;
        memArray[15] = 8'd12;
        memArray[5]  = 8'd7;
        memArray[6]  = 8'hF0;

        applyStimulus(1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("rst_we", memWe, 0);
        checkOutput("rst_done", done, 0);

        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_ready", instrReady, 1);
        checkOutput("idle_addr", memAddr, 0);
        checkOutput("idle_we", memWe, 0);
        checkOutput("idle_result", result, 0);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_illegal", illegal, 0);

        // ADD r3+r7 -> r2, then SUB held on the bus while busy
        applyStimulus(1'b0, 1'b1, 16'hB372);
        checkOutput("add_c0_ready", instrReady, 1);
        applyStimulus(1'b0, 1'b1, 16'hCE25);
        checkOutput("add_c1_busy", busy, 1);
        checkOutput("add_c1_ready", instrReady, 0);
        checkOutput("add_c1_addr", memAddr, 3);
        checkOutput("add_c1_we", memWe, 0);
        applyStimulus(1'b0, 1'b1, 16'hCE25);
        checkOutput("add_c2_addr", memAddr, 7);
        checkOutput("add_c2_we", memWe, 0);
        applyStimulus(1'b0, 1'b1, 16'hCE25);
        checkOutput("add_c3_we", memWe, 0);
        checkOutput("add_c3_done", done, 0);
        applyStimulus(1'b0, 1'b1, 16'hCE25);
        checkOutput("add_c4_done", done, 1);
        checkOutput("add_c4_we", memWe, 1);
        checkOutput("add_c4_addr", memAddr, 2);
        checkOutput("add_c4_wdata", memWdata, 8'd25);
        checkOutput("add_c4_result", result, 8'd25);
        checkOutput("add_c4_ready", instrReady, 1);

        // SUB r14-r2 -> r5, reading the freshly written r2
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("sub_c5_addr", memAddr, 14);
        checkOutput("sub_c5_we", memWe, 0);
        checkOutput("sub_c5_done", done, 0);
        checkOutput("add_mem2", memArray[2], 8'd25);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("sub_c6_addr", memAddr, 2);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("sub_c7_done", done, 0);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("sub_c8_done", done, 1);
        checkOutput("sub_c8_addr", memAddr, 5);
        checkOutput("sub_c8_wdata", memWdata, 8'hEA);

        // MUL r15*r5 -> r11
        applyStimulus(1'b0, 1'b1, 16'hDF5B);
        checkOutput("mul_c0_busy", busy, 0);
        checkOutput("sub_mem5", memArray[5], 8'hEA);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("mul_c1_addr", memAddr, 15);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("mul_c2_addr", memAddr, 5);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("mul_c4_done", done, 1);
        checkOutput("mul_c4_addr", memAddr, 11);
        checkOutput("mul_c4_wdata", memWdata, 8'hF8);
        checkOutput("mul_c4_result", result, 8'hF8);
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("mul_flag_c", flagC, 1);
        checkOutput("mul_flag_z", flagZ, 0);
`endif

        // Illegal opcode: ERR pulse one cycle after accept, no write, result held
        applyStimulus(1'b0, 1'b1, 16'h0123);
        checkOutput("ill_c0_ready", instrReady, 1);
        checkOutput("mul_mem11", memArray[11], 8'hF8);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("ill_c1_done", done, 1);
        checkOutput("ill_c1_illegal", illegal, 1);
        checkOutput("ill_c1_we", memWe, 0);
        checkOutput("ill_c1_ready", instrReady, 0);
        checkOutput("ill_c1_result", result, 8'hF8);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("ill_c2_done", done, 0);
        checkOutput("ill_c2_illegal", illegal, 0);
        checkOutput("ill_c2_busy", busy, 0);
        checkOutput("ill_c2_we", memWe, 0);

        // AND r6&r7 -> r7, destination equals a source
        applyStimulus(1'b0, 1'b1, 16'h8677);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("and_c1_addr", memAddr, 6);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("and_c2_addr", memAddr, 7);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("and_c4_done", done, 1);
        checkOutput("and_c4_addr", memAddr, 7);
        checkOutput("and_c4_wdata", memWdata, 8'h00);
        checkOutput("and_c4_result", result, 8'h00);
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("and_flag_z", flagZ, 1);
        checkOutput("and_flag_c", flagC, 0);
`endif

        // ADD r3+r13 -> r4 with reset asserted during its write-back cycle
        applyStimulus(1'b0, 1'b1, 16'hB3D4);
        checkOutput("and_mem7", memArray[7], 8'h00);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("rwb_exec_busy", busy, 1);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("rwb_we", memWe, 0);
        checkOutput("rwb_done", done, 0);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("rwb_busy", busy, 0);
        checkOutput("rwb_ready", instrReady, 1);
        checkOutput("rwb_addr", memAddr, 0);
        checkOutput("rwb_we_after", memWe, 0);
        checkOutput("rwb_wdata", memWdata, 0);
        checkOutput("rwb_result", result, 0);
        checkOutput("rwb_done_after", done, 0);
        checkOutput("rwb_illegal", illegal, 0);
        checkOutput("rwb_mem4", memArray[4], 8'h00);
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("rwb_flag_z", flagZ, 0);
        checkOutput("rwb_flag_c", flagC, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
